// File: rtl/calc_pkg.sv
// Shared types for the calculator key player: command encoding, player FSM states, key-class helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package calc_pkg;

    // Command codes as seen on the calculator cmd port.
    typedef enum logic [3:0] {
        D0   = 4'd0,
        D1   = 4'd1,
        D2   = 4'd2,
        D3   = 4'd3,
        D4   = 4'd4,
        D5   = 4'd5,
        D6   = 4'd6,
        D7   = 4'd7,
        D8   = 4'd8,
        D9   = 4'd9,
        ADD  = 4'b1010,
        SUB  = 4'b1011,
        MUL  = 4'b1100,
        NOP  = 4'b1101,
        EQ   = 4'b1110,
        BKSP = 4'b1111
    } cmd_t;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_HOLD,
        KP_GAP
    } kp_state_t;

    // Hold/gap counter width; comfortably covers any sensible hold parameter.
    localparam int HOLD_CW = 16;

    function automatic logic is_op(input cmd_t c);
        return (c == ADD) || (c == SUB) || (c == MUL);
    endfunction

endpackage

// File: rtl/calc_key_fifo.sv
// Small key FIFO: DEPTH entries of 4-bit key codes, combinational head (dout), registered pointers/count.
// Latency: a push is visible at dout/count one edge later; pop takes effect on the same edge.
// Backpressure: full is asserted at DEPTH entries; the caller must not push when full nor pop when empty.
// Ports: clock, reset (async active-low), push/din, pop, dout (head), full, empty, count (occupancy).
module calc_key_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [3:0]             din,
    input  logic                   pop,
    output logic [3:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/calc_key_player.sv
// Replays queued keystrokes onto the calculator cmd port, holding each for its class length, then a NOP gap.
// Latency: push into an empty, idle player reaches cmd on the 2nd edge; '=' holds long enough for multiply.
// Backpressure: key_ready drops while the FIFO is full; NOP/unknown codes are silently dropped at push.
// Ports: clock, reset (async active-low), key_valid/key_data/key_ready (push side),
//        cmd (registered command), busy, key_done (end-of-key pulse), count (queued keys).
module calc_key_player
    import calc_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DIGIT_HOLD = 10,
    parameter int OP_HOLD    = 15,
    parameter int EQ_HOLD    = 50,
    parameter int GAP        = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [3:0]             key_data,
    output logic                   key_ready,
    output logic [3:0]             cmd,
    output logic                   busy,
    output logic                   key_done,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = HOLD_CW;

    kp_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          done_q, done_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [3:0]    head;
    logic          push;
    logic          pop;
    logic          load;

    function automatic logic [CW-1:0] hold_len(input logic [3:0] k);
        if (is_op(cmd_t'(k))) begin
            return CW'(OP_HOLD);
        end else if (k == EQ) begin
            return CW'(EQ_HOLD);
        end
        return CW'(DIGIT_HOLD);
    endfunction

    // NOP carries no keystroke, so it never occupies a FIFO slot.
    assign key_ready = !fifo_full;
    assign push      = key_valid && !fifo_full && (key_data != NOP);

    calc_key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (key_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        load    = 1'b0;

        case (state_q)
            KP_IDLE: load = 1'b1;
            KP_HOLD: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d = KP_GAP;
                        cmd_d   = NOP;
                        cnt_d   = CW'(GAP - 1);
                    end else begin
                        // No gap: the last hold cycle doubles as the idle cycle,
                        // so a queued key follows back-to-back.
                        load = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            KP_GAP: begin
                if (cnt_q == '0) begin
                    state_d = KP_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = KP_IDLE;
        endcase

        if (load) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = KP_HOLD;
                cmd_d   = head;
                cnt_d   = hold_len(head) - 1'b1;
            end else begin
                state_d = KP_IDLE;
                cmd_d   = NOP;
                cnt_d   = '0;
            end
        end

        // key_done marks the final cycle of a key: last gap cycle, or last hold cycle when there is no gap.
        done_d = (cnt_d == '0) && ((state_d == KP_GAP) || ((GAP == 0) && (state_d == KP_HOLD)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= KP_IDLE;
            cnt_q   <= '0;
            cmd_q   <= NOP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            done_q  <= done_d;
        end
    end

    assign cmd      = cmd_q;
    assign key_done = done_q;
    assign busy     = (state_q != KP_IDLE) || (count != '0);

endmodule

// File: tb/tb_calc_key_player.sv
module tb_calc_key_player;
    import calc_pkg::*;

    localparam int DEPTH = 8;
    localparam int DH    = 10;
    localparam int OH    = 15;
    localparam int EH    = 50;
    localparam int GP    = 2;
    localparam int TL    = 8192;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid, key_ready, busy, key_done;
    logic [3:0] key_data, cmd;
    logic [3:0] count;
    logic       k0_vld, k0_rdy, busy0, done0;
    logic [3:0] k0_dat, cmd0;
    logic [3:0] count0;

    always #5 clock = ~clock;

    calc_key_player #(.DEPTH(DEPTH), .DIGIT_HOLD(DH), .OP_HOLD(OH), .EQ_HOLD(EH), .GAP(GP)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .cmd(cmd), .busy(busy), .key_done(key_done), .count(count));

    calc_key_player #(.DEPTH(DEPTH), .DIGIT_HOLD(DH), .OP_HOLD(OH), .EQ_HOLD(EH), .GAP(0)) dut0 (
        .clock(clock), .reset(reset), .key_valid(k0_vld), .key_data(k0_dat),
        .key_ready(k0_rdy), .cmd(cmd0), .busy(busy0), .key_done(done0), .count(count0));

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of pending keys plus a timeline of expected outputs per cycle.
    int         n;
    int         free_at;
    logic [3:0] q[$];
    logic [3:0] e_cmd[TL];
    bit         e_done[TL];
    bit         e_act[TL];
    int         seen[16];
    int         pulse_cnt;
    int         last_pulse;

    typedef struct {
        logic [3:0] key;
        int         hold;
        int         pulses;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic int exp_hold(input logic [3:0] k);
        if (k == 4'd10 || k == 4'd11 || k == 4'd12) return OH;
        if (k == 4'd14) return EH;
        if (k == 4'd13) return 0;
        return DH;
    endfunction

    task automatic model_reset();
        n = 0;
        free_at = 0;
        q.delete();
        for (int i = 0; i < TL; i++) begin
            e_cmd[i] = 4'd13;
            e_done[i] = 1'b0;
            e_act[i] = 1'b0;
        end
    endtask

    // Present inputs for the current cycle, advance one edge, check against the model.
    task automatic step(input logic v, input logic [3:0] d, output bit acc);
        int h;
        logic [3:0] k;
        key_valid = v;
        key_data  = d;
        acc = v && (d != 4'd13) && (q.size() < DEPTH);
        if (n >= free_at && q.size() > 0) begin
            k = q.pop_front();
            h = exp_hold(k);
            for (int t = n + 1; t <= n + h; t++) e_cmd[t] = k;
            for (int t = n + 1; t <= n + h + GP; t++) e_act[t] = 1'b1;
            e_done[n + h + GP] = 1'b1;
            free_at = n + h + GP + ((GP > 0) ? 1 : 0);
        end
        if (acc) q.push_back(d);
        @(posedge clock);
        #1;
        n++;
        if (n + 64 >= TL) begin
            failures++;
            $display("FAIL timeline_overflow: cycle %0d limit %0d", n, TL);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "timeline overflow");
        end
        chk("cmd", cmd, e_cmd[n]);
        chk("key_done", key_done, e_done[n]);
        chk("count", count, q.size());
        chk("key_ready", key_ready, q.size() < DEPTH);
        chk("busy", busy, e_act[n] || (q.size() != 0));
        if (!$isunknown(cmd)) seen[cmd]++;
        if (key_done) begin
            pulse_cnt++;
            last_pulse = n;
        end
    endtask

    task automatic push_key(input logic [3:0] k);
        bit acc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, k, acc);
            if (acc) break;
        end
        if (!acc) begin
            failures++;
            $display("FAIL push_timeout: key %0d not accepted", k);
        end
    endtask

    task automatic drain(input string name);
        bit acc;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            step(1'b0, 4'd0, acc);
        end
        chk(name, busy, 0);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) seen[i] = 0;
        pulse_cnt = 0;
        last_pulse = -1;
    endtask

    task automatic do_reset();
        key_valid = 1'b0; key_data = 4'd0; k0_vld = 1'b0; k0_dat = 4'd0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cmd", cmd, 13);
        chk("rst_busy", busy, 0);
        chk("rst_done", key_done, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", key_ready, 1);
        chk("rst_cmd0", cmd0, 13);
        chk("rst_count0", count0, 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        clear_stats();
    endtask

    initial begin
        bit acc;
        int tot, first1, last1;
        logic [3:0] seq1[6];
        logic [3:0] seq2[5];

        vecs[0] = '{4'd0,  DH, 1};
        vecs[1] = '{4'd9,  DH, 1};
        vecs[2] = '{4'd7,  DH, 1};
        vecs[3] = '{4'd10, OH, 1};
        vecs[4] = '{4'd11, OH, 1};
        vecs[5] = '{4'd12, OH, 1};
        vecs[6] = '{4'd14, EH, 1};
        vecs[7] = '{4'd15, DH, 1};
        vecs[8] = '{4'd13, 0,  0};
        seq1 = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd1, 4'd14};
        seq2 = '{4'd4, 4'd5, 4'd6, 4'd15, 4'd14};

        do_reset();

        // Single-key table: hold length per class and one done pulse; NOP is dropped.
        for (int v = 0; v < 9; v++) begin
            clear_stats();
            step(1'b1, vecs[v].key, acc);
            for (int i = 0; i < vecs[v].hold + GP + 6; i++) step(1'b0, 4'd0, acc);
            tot = 0;
            for (int k = 0; k < 16; k++) if (k != 13) tot += seen[k];
            chk("tbl_hold", tot, vecs[v].hold);
            chk("tbl_pulses", pulse_cnt, vecs[v].pulses);
        end

        // 1,2,3,+,1,=
        do_reset();
        foreach (seq1[i]) push_key(seq1[i]);
        drain("seq1_drained");
        chk("seq1_pulses", pulse_cnt, 6);
        chk("seq1_busy_fall", n - last_pulse, 1);
        chk("seq1_eq_hold", seen[14], EH);
        chk("seq1_add_hold", seen[10], OH);

        // 4,5,6,BKSP,=
        do_reset();
        foreach (seq2[i]) push_key(seq2[i]);
        drain("seq2_drained");
        chk("seq2_bksp_hold", seen[15], DH);
        chk("seq2_eq_hold", seen[14], EH);
        chk("seq2_pulses", pulse_cnt, 5);

        // Fill the FIFO while '=' is being held; the 9th push waits for the first pop.
        do_reset();
        push_key(4'd14);
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, acc);
        chk("full_pre_cmd", cmd, 14);
        for (int i = 1; i <= 8; i++) push_key(4'(i));
        chk("full_count", count, 8);
        chk("full_ready", key_ready, 0);
        step(1'b1, 4'd10, acc);
        chk("full_ninth_held", count, 8);
        push_key(4'd10);
        chk("full_after_pop", count, 8);
        drain("full_drained");

        // GAP=0 instance: two 1s merge into one continuous 20-cycle hold with two pulses.
        do_reset();
        first1 = -1; last1 = -1; tot = 0; pulse_cnt = 0;
        k0_vld = 1'b1; k0_dat = 4'd1;
        step(1'b0, 4'd0, acc);
        step(1'b0, 4'd0, acc);
        k0_vld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cmd0 == 4'd1) begin
                tot++;
                if (first1 < 0) first1 = n;
                last1 = n;
            end
            if (done0) pulse_cnt++;
            step(1'b0, 4'd0, acc);
        end
        chk("gap0_cycles", tot, 20);
        chk("gap0_contig", last1 - first1 + 1, 20);
        chk("gap0_pulses", pulse_cnt, 2);
        chk("gap0_busy", busy0, 0);

        // Random stream against the model.
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            step($urandom_range(0, 99) < 35, 4'($urandom_range(0, 15)), acc);
        end
        drain("rand_drained");

        // Asynchronous reset in the middle of an '=' hold.
        do_reset();
        push_key(4'd14);
        push_key(4'd3);
        push_key(4'd4);
        for (int i = 0; i < 15; i++) step(1'b0, 4'd0, acc);
        chk("arst_pre_cmd", cmd, 14);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cmd", cmd, 13);
        chk("arst_count", count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", key_done, 0);
        #1;
        reset = 1'b1;
        model_reset();
        step(1'b1, 4'd6, acc);
        step(1'b0, 4'd0, acc);
        chk("arst_six", cmd, 6);
        drain("arst_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
